// File: rtl/best_mv_select_if.sv
// best_mv_select_if: candidate stream into best_mv_select and per-partition winners/status back out
interface best_mv_select_if #(
   parameter int MV_W  = 7,
   parameter int CNT_W = 12
);
   logic                    start;
   logic                    sad_valid;
   logic                    last;
   logic signed [MV_W-1:0]  mv_x;
   logic signed [MV_W-1:0]  mv_y;
   logic [223:0]            SAD8x8;
   logic [63:0]             SAD16x16;
   logic [17:0]             SAD32x32;
   logic [223:0]            best_sad8x8;
   logic [63:0]             best_sad16x16;
   logic [17:0]             best_sad32x32;
   logic [16*2*MV_W-1:0]    best_mv8x8;
   logic [4*2*MV_W-1:0]     best_mv16x16;
   logic [2*MV_W-1:0]       best_mv32x32;
   logic [CNT_W-1:0]        cand_cnt;
   logic                    busy;
   logic                    done;

   modport master (
      output start, sad_valid, last, mv_x, mv_y, SAD8x8, SAD16x16, SAD32x32,
      input  best_sad8x8, best_sad16x16, best_sad32x32,
      input  best_mv8x8, best_mv16x16, best_mv32x32, cand_cnt, busy, done
   );

   modport slave (
      input  start, sad_valid, last, mv_x, mv_y, SAD8x8, SAD16x16, SAD32x32,
      output best_sad8x8, best_sad16x16, best_sad32x32,
      output best_mv8x8, best_mv16x16, best_mv32x32, cand_cnt, busy, done
   );
endinterface

// File: rtl/best_mv_select.sv
// best_mv_select: keeps the lowest-metric MV per 8x8/16x16/32x32 partition; MV_COST_EN adds |mv_x|+|mv_y| to the metric
module best_mv_select #(
   parameter int MV_W  = 7,
   parameter int CNT_W = 12
) (
   input logic             clk,
   input logic             rst_n,
   best_mv_select_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_clear;
   logic              w_accept;
   logic [CNT_W-1:0]  r_cnt;
   logic [2*MV_W-1:0] w_mv;

   assign w_mv = {bus.mv_y, bus.mv_x};

`ifdef MV_COST_EN
   logic [MV_W-1:0] w_abs_x;
   logic [MV_W-1:0] w_abs_y;
   logic [MV_W:0]   w_cost;
   assign w_abs_x = bus.mv_x[MV_W-1] ? MV_W'(-bus.mv_x) : MV_W'(bus.mv_x);
   assign w_abs_y = bus.mv_y[MV_W-1] ? MV_W'(-bus.mv_y) : MV_W'(bus.mv_y);
   assign w_cost  = {1'b0, w_abs_x} + {1'b0, w_abs_y};
`endif

   // state register; reset is active high despite the port name
   always_ff @(posedge clk) begin
      if (rst_n) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // next state: start always wins and restarts; a candidate is only taken in SEARCH
   always_comb begin
      w_next   = r_state;
      w_clear  = 1'b0;
      w_accept = 1'b0;
      if (bus.start) begin
         w_next  = S_SEARCH;
         w_clear = 1'b1;
      end else begin
         case (r_state)
            S_SEARCH: begin
               w_accept = bus.sad_valid;
               w_next   = (bus.sad_valid && bus.last) ? S_DONE : S_SEARCH;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   assign bus.busy = (r_state == S_SEARCH);
   assign bus.done = (r_state == S_DONE);

   // saturating count of accepted candidates
   always_ff @(posedge clk) begin
      if (rst_n || w_clear)              r_cnt <= '0;
      else if (w_accept && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
   end

   assign bus.cand_cnt = r_cnt;

   for (genvar k = 0; k < 16; k++) begin : g_8x8
      logic [13:0]       w_sad;
      logic              w_win;
      logic [13:0]       r_sad;
      logic [2*MV_W-1:0] r_mv;
      assign w_sad = bus.SAD8x8[14*k +: 14];
`ifdef MV_COST_EN
      logic [14:0] w_met;
      logic [14:0] r_met;
      assign w_met = 15'(w_sad) + 15'(w_cost);
      assign w_win = w_accept && (w_met < r_met);
      // cost-weighted metric of the current winner; all-ones so the first candidate always wins
      always_ff @(posedge clk) begin
         if (rst_n || w_clear) r_met <= '1;
         else if (w_win)       r_met <= w_met;
      end
`else
      assign w_win = w_accept && (w_sad < r_sad);
`endif
      // winner SAD/MV; strict compare keeps the earlier candidate on ties
      always_ff @(posedge clk) begin
         if (rst_n || w_clear) begin
            r_sad <= '1;
            r_mv  <= '0;
         end else if (w_win) begin
            r_sad <= w_sad;
            r_mv  <= w_mv;
         end
      end
      assign bus.best_sad8x8[14*k +: 14]           = r_sad;
      assign bus.best_mv8x8[2*MV_W*k +: 2*MV_W]    = r_mv;
   end

   for (genvar k = 0; k < 4; k++) begin : g_16x16
      logic [15:0]       w_sad;
      logic              w_win;
      logic [15:0]       r_sad;
      logic [2*MV_W-1:0] r_mv;
      assign w_sad = bus.SAD16x16[16*k +: 16];
`ifdef MV_COST_EN
      logic [16:0] w_met;
      logic [16:0] r_met;
      assign w_met = 17'(w_sad) + 17'(w_cost);
      assign w_win = w_accept && (w_met < r_met);
      // cost-weighted metric of the current winner; all-ones so the first candidate always wins
      always_ff @(posedge clk) begin
         if (rst_n || w_clear) r_met <= '1;
         else if (w_win)       r_met <= w_met;
      end
`else
      assign w_win = w_accept && (w_sad < r_sad);
`endif
      // winner SAD/MV; strict compare keeps the earlier candidate on ties
      always_ff @(posedge clk) begin
         if (rst_n || w_clear) begin
            r_sad <= '1;
            r_mv  <= '0;
         end else if (w_win) begin
            r_sad <= w_sad;
            r_mv  <= w_mv;
         end
      end
      assign bus.best_sad16x16[16*k +: 16]         = r_sad;
      assign bus.best_mv16x16[2*MV_W*k +: 2*MV_W]  = r_mv;
   end

   logic [17:0]       w_sad32;
   logic              w_win32;
   logic [17:0]       r_sad32;
   logic [2*MV_W-1:0] r_mv32;
   assign w_sad32 = bus.SAD32x32;
`ifdef MV_COST_EN
   logic [18:0] w_met32;
   logic [18:0] r_met32;
   assign w_met32 = 19'(w_sad32) + 19'(w_cost);
   assign w_win32 = w_accept && (w_met32 < r_met32);
   // cost-weighted metric of the 32x32 winner
   always_ff @(posedge clk) begin
      if (rst_n || w_clear) r_met32 <= '1;
      else if (w_win32)     r_met32 <= w_met32;
   end
`else
   assign w_win32 = w_accept && (w_sad32 < r_sad32);
`endif

   // 32x32 winner SAD/MV
   always_ff @(posedge clk) begin
      if (rst_n || w_clear) begin
         r_sad32 <= '1;
         r_mv32  <= '0;
      end else if (w_win32) begin
         r_sad32 <= w_sad32;
         r_mv32  <= w_mv;
      end
   end

   assign bus.best_sad32x32 = r_sad32;
   assign bus.best_mv32x32  = r_mv32;
endmodule

// File: tb/tb_best_mv_select.sv
// tb_best_mv_select: randomized and directed checks of best_mv_select against a behavioural model
module tb_best_mv_select;
   localparam int MV_W  = 7;
   localparam int CNT_W = 12;
`ifdef MV_COST_EN
   localparam bit COST = 1'b1;
`else
   localparam bit COST = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;
   bit   chk_en = 1'b0;

   best_mv_select_if #(.MV_W(MV_W), .CNT_W(CNT_W)) bus ();
   best_mv_select #(.MV_W(MV_W), .CNT_W(CNT_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

   always #5 clk = ~clk;

   // model: 0 idle, 1 searching, 2 done; per-partition p: 0..15 8x8, 16..19 16x16, 20 32x32
   int m_ph = 0;
   int m_cnt = 0;
   int m_sad [21];
   int m_met [21];
   int m_mx  [21];
   int m_my  [21];

   function automatic int sw(int p);
      return p < 16 ? 14 : (p < 20 ? 16 : 18);
   endfunction

   function automatic int in_sad(int p);
      if (p < 16) return int'(bus.SAD8x8[14*p +: 14]);
      if (p < 20) return int'(bus.SAD16x16[16*(p-16) +: 16]);
      return int'(bus.SAD32x32);
   endfunction

   function automatic int iabs(int v);
      return v < 0 ? -v : v;
   endfunction

   task automatic m_clear();
      m_cnt = 0;
      for (int p = 0; p < 21; p++) begin
         m_sad[p] = (1 << sw(p)) - 1;
         m_met[p] = COST ? (1 << (sw(p) + 1)) - 1 : m_sad[p];
         m_mx[p]  = 0;
         m_my[p]  = 0;
      end
   endtask

   always @(posedge clk) begin
      if (rst_n) begin
         m_ph = 0;
         m_clear();
      end else if (bus.start) begin
         m_ph = 1;
         m_clear();
      end else if (m_ph == 1 && bus.sad_valid) begin
         int x, y;
         x = int'(bus.mv_x);
         y = int'(bus.mv_y);
         if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
         for (int p = 0; p < 21; p++) begin
            int s, m;
            s = in_sad(p);
            m = s + (COST ? iabs(x) + iabs(y) : 0);
            if (m < m_met[p]) begin
               m_met[p] = m;
               m_sad[p] = s;
               m_mx[p]  = x;
               m_my[p]  = y;
            end
         end
         if (bus.last) m_ph = 2;
      end else if (m_ph == 2) begin
         m_ph = 0;
      end
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : cmp
      logic [223:0] e8, em8;
      logic [63:0]  e16;
      logic [55:0]  em16;
      logic [17:0]  e32;
      logic [13:0]  em32;
      if (chk_en) begin
         for (int p = 0; p < 16; p++) begin
            e8[14*p +: 14]  = 14'(m_sad[p]);
            em8[14*p +: 14] = {7'(m_my[p]), 7'(m_mx[p])};
         end
         for (int p = 0; p < 4; p++) begin
            e16[16*p +: 16]  = 16'(m_sad[16+p]);
            em16[14*p +: 14] = {7'(m_my[16+p]), 7'(m_mx[16+p])};
         end
         e32  = 18'(m_sad[20]);
         em32 = {7'(m_my[20]), 7'(m_mx[20])};
         chk("busy", 256'(bus.busy), 256'(m_ph == 1));
         chk("done", 256'(bus.done), 256'(m_ph == 2));
         chk("cand_cnt", 256'(bus.cand_cnt), 256'(m_cnt));
         chk("sad8x8", 256'(bus.best_sad8x8), 256'(e8));
         chk("sad16x16", 256'(bus.best_sad16x16), 256'(e16));
         chk("sad32x32", 256'(bus.best_sad32x32), 256'(e32));
         chk("mv8x8", 256'(bus.best_mv8x8), 256'(em8));
         chk("mv16x16", 256'(bus.best_mv16x16), 256'(em16));
         chk("mv32x32", 256'(bus.best_mv32x32), 256'(em32));
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic drv(input bit s, input bit v, input bit l, input int x, input int y,
                      input int s8, input int s16, input int s32);
      bus.start     = s;
      bus.sad_valid = v;
      bus.last      = l;
      bus.mv_x      = 7'(x);
      bus.mv_y      = 7'(y);
      bus.SAD8x8    = {16{14'(s8)}};
      bus.SAD16x16  = {4{16'(s16)}};
      bus.SAD32x32  = 18'(s32);
      tick();
   endtask

   function automatic int rs(int w);
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return (1 << w) - 1;
      if (r == 1) return $urandom_range(0, (1 << w) - 1);
      return $urandom_range(0, 30);
   endfunction

   task automatic rnd_inputs();
      bus.start     = ($urandom_range(0, 39) == 0);
      bus.sad_valid = 1'($urandom_range(0, 1));
      bus.last      = ($urandom_range(0, 11) == 0);
      bus.mv_x      = 7'($urandom);
      bus.mv_y      = 7'($urandom);
      for (int k = 0; k < 16; k++) bus.SAD8x8[14*k +: 14] = 14'(rs(14));
      for (int k = 0; k < 4; k++)  bus.SAD16x16[16*k +: 16] = 16'(rs(16));
      bus.SAD32x32 = 18'(rs(18));
   endtask

   initial begin
      rst_n = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
      chk_en = 1'b1;
      chk("rst_busy", 256'(bus.busy), 256'(0));
      chk("rst_cnt", 256'(bus.cand_cnt), 256'(0));
      chk("rst_sad32", 256'(bus.best_sad32x32), 256'(18'h3FFFF));
      chk("rst_mv8", 256'(bus.best_mv8x8), 256'(0));
      rst_n = 1'b0;
      drv(0, 1, 1, 1, 1, 5, 5, 5);
      chk("idle_ignores_valid", 256'(bus.cand_cnt), 256'(0));

      // single candidate, results then a done pulse
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      chk("start_busy", 256'(bus.busy), 256'(1));
      drv(0, 1, 1, 3, -2, 100, 400, 1600);
      chk("r032_sad8", 256'(bus.best_sad8x8), 256'({16{14'd100}}));
      chk("r032_sad16", 256'(bus.best_sad16x16), 256'({4{16'd400}}));
      chk("r032_sad32", 256'(bus.best_sad32x32), 256'(1600));
      chk("r032_mv32", 256'(bus.best_mv32x32), 256'(14'h3F03));
      chk("r032_mv8", 256'(bus.best_mv8x8), 256'({16{14'h3F03}}));
      chk("r032_cnt", 256'(bus.cand_cnt), 256'(1));
      chk("r032_done", 256'(bus.done), 256'(1));
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("r032_done_off", 256'(bus.done), 256'(0));
      chk("r032_hold", 256'(bus.best_sad32x32), 256'(1600));

      // tie keeps first
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 1, 0, 0, 0, 1000, 1000, 500);
      drv(0, 1, 0, 1, 1, 1000, 1000, 300);
      drv(0, 1, 1, 2, 2, 1000, 1000, 300);
      chk("r033_sad32", 256'(bus.best_sad32x32), 256'(300));
      chk("r033_mv32", 256'(bus.best_mv32x32), 256'(14'h081));

      // independent 8x8 trackers
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      bus.start = 0; bus.sad_valid = 1; bus.last = 0; bus.mv_x = 0; bus.mv_y = 0;
      bus.SAD8x8 = {16{14'd50}};
      bus.SAD8x8[13:0] = 14'd10;
      bus.SAD8x8[223:210] = 14'd90;
      tick();
      bus.last = 1;
      bus.SAD8x8[13:0] = 14'd20;
      bus.SAD8x8[223:210] = 14'd5;
      tick();
      chk("r034_e0", 256'(bus.best_sad8x8[13:0]), 256'(10));
      chk("r034_e15", 256'(bus.best_sad8x8[223:210]), 256'(5));

      // restart mid-search, then reset mid-search
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 1, 0, 1, 1, 7, 7, 200);
      drv(0, 1, 0, 1, 1, 7, 7, 150);
      chk("r035_cnt2", 256'(bus.cand_cnt), 256'(2));
      drv(1, 1, 1, 0, 0, 3, 3, 5);
      chk("r035_cnt0", 256'(bus.cand_cnt), 256'(0));
      chk("r035_sad32", 256'(bus.best_sad32x32), 256'(18'h3FFFF));
      chk("r035_nodone", 256'(bus.done), 256'(0));
      drv(0, 0, 1, 0, 0, 3, 3, 5);
      chk("last_needs_valid", 256'(bus.busy), 256'(1));
      drv(0, 1, 0, 0, 0, 3, 3, 5);
      rst_n = 1'b1;
      drv(1, 1, 1, 0, 0, 3, 3, 5);
      rst_n = 1'b0;
      chk("r035_rst_busy", 256'(bus.busy), 256'(0));
      chk("r035_rst_cnt", 256'(bus.cand_cnt), 256'(0));
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("r035_rst_nodone", 256'(bus.done), 256'(0));

      // MV cost decides between close SADs
      drv(1, 0, 0, 0, 0, 0, 0, 0);
      drv(0, 1, 0, 10, 10, 9, 9, 100);
      drv(0, 1, 1, 0, 0, 9, 9, 110);
      chk("r036_sad32", 256'(bus.best_sad32x32), 256'(COST ? 110 : 100));
      chk("r036_mv32", 256'(bus.best_mv32x32), 256'(COST ? 14'h000 : 14'h50A));

      // start with a concurrent candidate in IDLE: start wins
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      drv(1, 1, 0, 4, 4, 1, 1, 1);
      chk("r026_cnt", 256'(bus.cand_cnt), 256'(0));
      chk("r026_sad32", 256'(bus.best_sad32x32), 256'(18'h3FFFF));

      // counter saturation
      for (int i = 0; i < 4100; i++) begin
         rnd_inputs();
         bus.start = 0; bus.sad_valid = 1; bus.last = 0;
         tick();
      end
      chk("sat_cnt", 256'(bus.cand_cnt), 256'(12'hFFF));
      drv(0, 1, 1, 0, 0, 0, 0, 0);
      chk("sat_done", 256'(bus.done), 256'(1));

      // randomized traffic with occasional restarts and resets
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 199) == 0);
         rnd_inputs();
         tick();
      end
      rst_n = 1'b0;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
